// File: rtl/instruction_encoder.sv
// RV32I field packer feeding a small circular FIFO with per-word write addresses.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instruction_encoder #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 fmt,
   input  logic [6:0]                 opcode,
   input  logic [2:0]                 funct3,
   input  logic [6:0]                 funct7,
   input  logic [4:0]                 rd,
   input  logic [4:0]                 rs1,
   input  logic [4:0]                 rs2,
   input  logic [31:0]                imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data,
   output logic [31:0]                out_addr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [31:0]   enc_word;
   logic          fmt_ok;
   logic          imm_ok;
   logic          accept;
   logic          push;
   logic          pop;

   always_comb begin
      enc_word = 32'h0;
      fmt_ok   = 1'b1;
      case (fmt)
         FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U: enc_word = {imm[31:12], rd, opcode};
         FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: fmt_ok = 1'b0;
      endcase
   end

`ifdef ENC_IMM_CHECK_EN
   // Immediate must be representable by the format's sign-extended field.
   always_comb begin
      imm_ok = 1'b1;
      case (fmt)
         FMT_I, FMT_S: imm_ok = (imm[31:11] == {21{imm[11]}});
         FMT_B:        imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
         FMT_J:        imm_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
         FMT_U:        imm_ok = (imm[11:0] == 12'h0);
         default:      imm_ok = 1'b1;
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && fmt_ok && imm_ok;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rptr] : 32'h0;

   // Storage is not reset; stale entries are hidden by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         out_addr <= BASE_ADDR;
         err      <= 1'b0;
      end else begin
         err <= accept && !(fmt_ok && imm_ok);
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr     <= rptr + AW'(1);
            out_addr <= out_addr + 32'd4;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder (DEPTH=4, nonzero base address).
module tb_instruction_encoder;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_addr;
   logic [2:0]  count;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_addr;
   logic [31:0] bp_word [DEPTH];

   instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .count(count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_b(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
      in_valid = 1'b1;
      fmt = f; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
   endtask

   // Push with out_ready=1 and a drained FIFO: each new word shows up alone at the head.
   task automatic push_stream(input string tag, input logic [31:0] exp);
      step();
      chk({tag, "_data"}, out_data, exp);
      chk({tag, "_addr"}, out_addr, exp_addr);
      chk({tag, "_cnt"}, 32'(count), 32'd1);
      exp_addr += 4;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_b(0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_addr", out_addr, BASE);
      chk("rst_err", 32'(err), 0);
      chk("rst_ready", 32'(in_ready), 1);

      // add x3,x1,x2
      set_b(0, 7'h33, 0, 0, 3, 1, 2, 0);
      step();
      in_valid = 1'b0;
      chk("r_valid", 32'(out_valid), 1);
      chk("r_data", out_data, 32'h002081B3);
      chk("r_addr", out_addr, BASE);
      out_ready = 1'b1;
      step();
      chk("r_drain_cnt", 32'(count), 0);
      chk("r_drain_addr", out_addr, BASE + 4);
      exp_addr = BASE + 4;

      set_b(1, 7'h13, 0, 0, 5, 0, 0, 32'hFFFF_FFFF); push_stream("addi", 32'hFFF00293);
      set_b(2, 7'h23, 2, 0, 0, 1, 2, 32'd8);         push_stream("sw",   32'h0020A423);
      set_b(3, 7'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC); push_stream("beq",  32'hFE208EE3);
      set_b(5, 7'h6F, 0, 0, 1, 0, 0, 32'd2048);      push_stream("jal",  32'h001000EF);
      set_b(4, 7'h37, 0, 0, 1, 0, 0, 32'h1234_5000); push_stream("lui",  32'h123450B7);
      in_valid = 1'b0;
      step();
      chk("b2b_empty", 32'(count), 0);
      chk("b2b_addr", out_addr, exp_addr);

      // Backpressure: DEPTH+1 pushes with consumer stalled
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) begin
         bp_word[k % DEPTH] = (k < DEPTH) ? {12'(k + 1), 5'd0, 3'd0, 5'(k), 7'h13} : bp_word[k % DEPTH];
         set_b(1, 7'h13, 0, 0, 5'(k), 0, 0, 32'(k + 1));
         step();
      end
      in_valid = 1'b0;
      chk("bp_full_cnt", 32'(count), DEPTH);
      chk("bp_full_rdy", 32'(in_ready), 0);
      out_ready = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         chk($sformatf("bp_data%0d", j), out_data, bp_word[j]);
         chk($sformatf("bp_addr%0d", j), out_addr, exp_addr);
         step();
         exp_addr += 4;
      end
      chk("bp_empty_cnt", 32'(count), 0);
      chk("bp_empty_valid", 32'(out_valid), 0);
      chk("bp_empty_data", out_data, 0);

      // Simultaneous push and pop at count=2
      out_ready = 1'b0;
      set_b(0, 7'h33, 0, 0, 1, 0, 0, 0); step();   // 0x000000B3
      set_b(0, 7'h33, 0, 0, 2, 0, 0, 0); step();   // 0x00000133
      chk("pp_cnt_before", 32'(count), 2);
      set_b(0, 7'h33, 0, 0, 3, 0, 0, 0);           // 0x000001B3
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      exp_addr += 4;
      chk("pp_cnt_hold", 32'(count), 2);
      chk("pp_head", out_data, 32'h00000133);
      step(); step();
      exp_addr += 8;
      chk("pp_drained", 32'(count), 0);
      chk("pp_addr", out_addr, exp_addr);

      // Illegal format
      set_b(7, 7'h33, 0, 0, 1, 0, 0, 0);
      chk("ill_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("ill_err", 32'(err), 1);
      chk("ill_cnt", 32'(count), 0);
      step();
      chk("ill_err_clr", 32'(err), 0);
      set_b(6, 7'h33, 0, 0, 1, 0, 0, 0);
      step();
      in_valid = 1'b0;
      chk("ill6_err", 32'(err), 1);
      chk("ill6_cnt", 32'(count), 0);

      // Out-of-range immediate on addi x5,x0,4096
      out_ready = 1'b0;
      set_b(1, 7'h13, 0, 0, 5, 0, 0, 32'd4096);
      step();
      in_valid = 1'b0;
`ifdef ENC_IMM_CHECK_EN
      chk("imm_err", 32'(err), 1);
      chk("imm_cnt", 32'(count), 0);
`else
      chk("imm_err", 32'(err), 0);
      chk("imm_cnt", 32'(count), 1);
      chk("imm_data", out_data, 32'h00000293);
      out_ready = 1'b1;
      step();
      exp_addr += 4;
`endif

      // Reset mid-operation with count=3 and out_addr=BASE+8
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 1'b1;
      set_b(0, 7'h33, 0, 0, 1, 0, 0, 0); step(); step(); step();
      out_ready = 1'b0;
      step(); step();
      in_valid = 1'b0;
      chk("mid_cnt", 32'(count), 3);
      chk("mid_addr", out_addr, BASE + 8);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("mrst_cnt", 32'(count), 0);
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_addr", out_addr, BASE);
      chk("mrst_err", 32'(err), 0);
      chk("mrst_ready", 32'(in_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
